// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack stage behind the FP adder normalizer.
// Two-stage valid/ready pipeline: S1 captures operands and rounding decision, S2 holds the packed result.
module fp_round_pack #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [7:0]         in_exponent,
  input  logic [22:0]        in_mantissa,
  input  logic               in_guard,
  input  logic               in_round,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic               out_inexact,
  output logic               out_overflow,
  output logic [COUNT_W-1:0] result_count,
  output logic [COUNT_W-1:0] inexact_count
);

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Stage S1 state
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_mant_q;
  logic             s1_round_up_q;
  logic             s1_inexact_q;

  // Stage S2 state
  logic             s2_valid_q;
  logic [RES_W-1:0] s2_result_q;
  logic             s2_inexact_q;
  logic             s2_overflow_q;

  logic [COUNT_W-1:0] result_count_q;
  logic [COUNT_W-1:0] inexact_count_q;

  logic             s1_adv_c;
  logic             s2_adv_c;
  logic             handoff_c;
  logic             special_c;
  logic [MAN_W:0]   sum_c;
  logic [EXP_W-1:0] exp_inc_c;
  logic [RES_W-1:0] s2_result_d;
  logic             s2_inexact_d;
  logic             s2_overflow_d;

  assign s2_adv_c  = !s2_valid_q || out_ready;
  assign s1_adv_c  = !s1_valid_q || s2_adv_c;
  assign in_ready  = s1_adv_c;
  assign handoff_c = s2_valid_q && out_ready;

  // S1: capture operands with the RNE round-up and inexact decisions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_mant_q     <= '0;
      s1_round_up_q <= 1'b0;
      s1_inexact_q  <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q     <= in_sign;
        s1_exp_q      <= in_exponent;
        s1_mant_q     <= in_mantissa;
        s1_round_up_q <= in_guard & (in_round | in_sticky | in_mantissa[0]);
        s1_inexact_q  <= in_guard | in_round | in_sticky;
      end
    end
  end

  assign special_c = (s1_exp_q == EXP_MAX);
  assign sum_c     = {1'b0, s1_mant_q} + (MAN_W+1)'(s1_round_up_q);
  assign exp_inc_c = s1_exp_q + EXP_W'(1);

  // Apply rounding, mantissa carry and overflow to infinity; NaN/Inf inputs bypass rounding
  always_comb begin
    s2_result_d   = {s1_sign_q, s1_exp_q, sum_c[MAN_W-1:0]};
    s2_inexact_d  = s1_inexact_q;
    s2_overflow_d = 1'b0;
    if (special_c) begin
      s2_result_d  = {s1_sign_q, s1_exp_q, s1_mant_q};
      s2_inexact_d = 1'b0;
    end else if (sum_c[MAN_W]) begin
      if (exp_inc_c == EXP_MAX) begin
        s2_result_d   = {s1_sign_q, EXP_MAX, {MAN_W{1'b0}}};
        s2_inexact_d  = 1'b1;
        s2_overflow_d = 1'b1;
      end else begin
        s2_result_d = {s1_sign_q, exp_inc_c, {MAN_W{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_inexact_q  <= 1'b0;
      s2_overflow_q <= 1'b0;
    end else if (s2_adv_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q   <= s2_result_d;
        s2_inexact_q  <= s2_inexact_d;
        s2_overflow_q <= s2_overflow_d;
      end
    end
  end

  // Handoff counters, wrapping naturally at 2^COUNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count_q  <= '0;
      inexact_count_q <= '0;
    end else if (handoff_c) begin
      result_count_q <= result_count_q + COUNT_W'(1);
      if (s2_inexact_q) begin
        inexact_count_q <= inexact_count_q + COUNT_W'(1);
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_result    = s2_result_q;
  assign out_inexact   = s2_inexact_q;
  assign out_overflow  = s2_overflow_q;
  assign result_count  = result_count_q;
  assign inexact_count = inexact_count_q;

endmodule
